// File: rtl/sys_pkg.sv
// sys_pkg: shared types and sizing helpers for the systolic summing blocks
// (sys_skewer, sys_sum, sys_stacker).
//   state_e      - skewer FSM states
//   cnt_width()  - bits needed to hold 0..max_val, never less than 1
//   lane_vec_t   - lane vector at the default geometry
package sys_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Default geometry; modules override through their own parameters.
    localparam int BIT_SIZE_DEF   = 4;
    localparam int NERVES_DEF     = 4;
    localparam int DEPTH_IN_DEF   = 2;

    // Counter widths at the default geometry: input count 0..DepthIn,
    // drain count 0..NumOfNerves-1.
    localparam int IN_CNT_W_DEF    = $clog2(DEPTH_IN_DEF + 1);
    localparam int DRAIN_CNT_W_DEF = $clog2(NERVES_DEF);

    typedef logic [NERVES_DEF-1:0][BIT_SIZE_DEF-1:0] lane_vec_t;

    // Width of a counter spanning 0..max_val; clamped to 1 so degenerate
    // geometries never produce zero-width vectors.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sys_delay_line.sv
// sys_delay_line: fixed-length shift register used to skew one lane.
//   clk   - rising-edge clock
//   res_n - synchronous active-high reset, clears every stage
//   din   - lane input
//   dout  - din delayed by Depth cycles (Depth=0 is a plain wire)
module sys_delay_line #(
    parameter int Depth = 1,
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    if (Depth == 0) begin : g_wire
        assign dout = din;
    end else begin : g_sr
        logic [Depth-1:0][Width-1:0] stage_q;
        logic [Depth-1:0][Width-1:0] stage_d;

        always_comb begin
            stage_d[0] = din;
            for (int i = 1; i < Depth; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (res_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[Depth-1];
    end

endmodule

// File: rtl/sys_skewer.sv
// sys_skewer: turns a frame of DepthIn row-aligned vectors into the diagonal
// stream consumed by sys_sum. Lane j is delayed j cycles; empty diagonal
// slots carry zero. Framing (out_valid/out_start/out_last) is generated here.
//   clk, res_n      - clock, synchronous active-high reset
//   in_valid/start  - input vector valid / first vector of a frame
//   in_data         - aligned vector, lane 0 at LSB
//   in_ready        - vector can be accepted this cycle (low while draining)
//   out_valid/start/last, out_data - skewed slot and its framing
//   err             - sticky protocol error (stray data, early termination)
module sys_skewer
    import sys_pkg::*;
#(
    parameter int BitSize     = 4,
    parameter int NumOfNerves = 4,
    parameter int DepthIn     = 2
) (
    input  logic                                  clk,
    input  logic                                  res_n,
    input  logic                                  in_valid,
    input  logic                                  in_start,
    input  logic [NumOfNerves-1:0][BitSize-1:0]   in_data,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic                                  out_start,
    output logic                                  out_last,
    output logic [NumOfNerves-1:0][BitSize-1:0]   out_data,
    output logic                                  err
);

    localparam int IN_CNT_W    = cnt_width(DepthIn);
    localparam int DRAIN_CNT_W = cnt_width(NumOfNerves - 1);

    localparam logic [IN_CNT_W-1:0]    IN_CNT_FINAL = IN_CNT_W'(DepthIn - 1);
    // Remaining drain cycles after a complete frame.
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_FULL   = DRAIN_CNT_W'(NumOfNerves - 1);
    // After early termination the terminating cycle is itself the first
    // drain slot, so one fewer cycle is left.
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_EARLY  =
        DRAIN_CNT_W'((NumOfNerves > 2) ? NumOfNerves - 2 : 0);

    state_e                             state_q, state_d;
    logic [IN_CNT_W-1:0]                in_cnt_q, in_cnt_d;
    logic [DRAIN_CNT_W-1:0]             drain_cnt_q, drain_cnt_d;
    logic                               err_q, err_d;
    logic                               out_valid_q, out_valid_d;
    logic                               out_start_q, out_start_d;
    logic                               out_last_q, out_last_d;
    logic [NumOfNerves-1:0][BitSize-1:0] out_data_q, out_data_d;

    logic                               take;
    logic [NumOfNerves-1:0][BitSize-1:0] lane_in;
    logic [NumOfNerves-1:0][BitSize-1:0] lane_dly;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (res_n) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next state, counters and framing of the slot produced at this edge
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_start_d = 1'b0;
        out_last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_start) begin
                        in_cnt_d    = IN_CNT_W'(1);
                        out_valid_d = 1'b1;
                        out_start_d = 1'b1;
                        if (DepthIn == 1) begin
                            if (NumOfNerves == 1) begin
                                out_last_d = 1'b1;
                            end else begin
                                state_d     = DRAIN;
                                drain_cnt_d = DRAIN_FULL;
                            end
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        // Data without a frame start is dropped.
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                // Every LOAD cycle is a slot: either a real vector or the
                // zero-filled slot of an early termination.
                out_valid_d = 1'b1;
                out_start_d = 1'b1;
                if (in_valid) begin
                    in_cnt_d = in_cnt_q + IN_CNT_W'(1);
                    if (in_cnt_q == IN_CNT_FINAL) begin
                        if (NumOfNerves == 1) begin
                            out_last_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d     = DRAIN;
                            drain_cnt_d = DRAIN_FULL;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                    if (NumOfNerves <= 2) begin
                        out_last_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_EARLY;
                    end
                end
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                if (drain_cnt_q == DRAIN_CNT_W'(1)) begin
                    out_last_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs, decoded from state
    always_comb begin
        in_ready = (state_q != DRAIN);
        take     = in_valid && in_ready && (state_q != IDLE || in_start);
    end

    // Lane inputs are zero unless a vector is taken, so the delay lines
    // flush themselves with the zero diagonal padding.
    always_comb begin
        for (int j = 0; j < NumOfNerves; j++) begin
            lane_in[j]    = take ? in_data[j] : '0;
            out_data_d[j] = out_valid_d ? lane_dly[j] : '0;
        end
    end

    for (genvar j = 0; j < NumOfNerves; j++) begin : g_lane
        if (j == 0) begin : g_direct
            assign lane_dly[j] = lane_in[j];
        end else begin : g_dly
            sys_delay_line #(
                .Depth (j),
                .Width (BitSize)
            ) u_dly (
                .clk   (clk),
                .res_n (res_n),
                .din   (lane_in[j]),
                .dout  (lane_dly[j])
            );
        end
    end

    assign out_valid = out_valid_q;
    assign out_start = out_start_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule
